// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared constants for the seven-segment scan controller
package display_scan_ctrl_pkg;

    // Segment patterns are active-low, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] DIGIT0_ONEHOT = 4'b0001;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// rtl/display_scan_ctrl_hex_to_seg7.sv - nibble to active-low seven-segment decoder
module hex_to_seg7
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup; every nibble has a glyph so no default blanking is needed
    always_comb begin
        seg = SEG_HEX_0;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit time-multiplexed seven-segment scan controller
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  digit_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre;
    logic [15:0]   shadow;
    logic          advance;
    logic [3:0]    next_sel;
    logic [1:0]    next_idx;
    logic [3:0]    next_nib;
    logic          next_blank;
    logic [6:0]    next_seg;

    // Advance strobe and the digit that the next slot will light
    always_comb begin
        advance  = (pre == PRE_LAST);
        next_sel = DIGIT0_ONEHOT;
        next_idx = 2'd0;
        case (digit_sel)
            4'b0001: begin next_sel = 4'b0010; next_idx = 2'd1; end
            4'b0010: begin next_sel = 4'b0100; next_idx = 2'd2; end
            4'b0100: begin next_sel = 4'b1000; next_idx = 2'd3; end
            4'b1000: begin next_sel = 4'b0001; next_idx = 2'd0; end
            default: begin next_sel = DIGIT0_ONEHOT; next_idx = 2'd0; end
        endcase
    end

    // Nibble and leading-zero decision for the upcoming digit, from the current shadow
    always_comb begin
        next_nib   = shadow[3:0];
        next_blank = 1'b0;
        case (next_idx)
            2'd0: begin next_nib = shadow[3:0];   next_blank = 1'b0; end
            2'd1: begin next_nib = shadow[7:4];   next_blank = blank_lz && (shadow[15:4] == 12'h000); end
            2'd2: begin next_nib = shadow[11:8];  next_blank = blank_lz && (shadow[15:8] == 8'h00); end
            2'd3: begin next_nib = shadow[15:12]; next_blank = blank_lz && (shadow[15:12] == 4'h0); end
            default: begin next_nib = shadow[3:0]; next_blank = 1'b0; end
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (next_nib),
        .seg    (next_seg)
    );

    // Refresh prescaler: one digit slot every PRESCALE cycles
    always_ff @(posedge clk) begin
        if (reset)        pre <= '0;
        else if (advance) pre <= '0;
        else              pre <= pre + CW'(1);
    end

    // Registered advance pulse
    always_ff @(posedge clk) begin
        if (reset) tick <= 1'b0;
        else       tick <= advance;
    end

    // Digit index and its anode/segment/dp pattern change together at the advance edge
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel <= DIGIT0_ONEHOT;
            an        <= ~DIGIT0_ONEHOT;
            seg       <= SEG_HEX_0;
            dp        <= 1'b1;
        end else if (advance) begin
            digit_sel <= next_sel;
            an        <= next_blank ? 4'b1111 : ~next_sel;
            seg       <= next_blank ? SEG_BLANK : next_seg;
            dp        <= next_blank ? 1'b1 : ~dp_en[next_idx];
        end
    end

    // Shadow register; a new value only reaches the pins at a later advance
    always_ff @(posedge clk) begin
        if (reset)     shadow <= 16'h0000;
        else if (load) shadow <= value;
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_en;

    logic [3:0] ds4, an4, ds1, an1;
    logic [6:0] seg4, seg1;
    logic       dp4, tk4, dp1, tk1;

    int total = 0;
    int bad = 0;
    bit started = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state: index 0 -> PRESCALE=4 instance, index 1 -> PRESCALE=1 instance
    int          m_cnt [2];
    int          m_d   [2];
    logic [15:0] m_sh  [2];
    logic [3:0]  m_an  [2];
    logic [6:0]  m_seg [2];
    logic        m_dp  [2];
    logic        m_tk  [2];

    display_scan_ctrl #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_en(dp_en), .digit_sel(ds4), .an(an4), .seg(seg4), .dp(dp4), .tick(tk4));

    display_scan_ctrl #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_en(dp_en), .digit_sel(ds1), .an(an1), .seg(seg1), .dp(dp1), .tick(tk1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit-level model: slot counter, digit number, shadow value
    task automatic model_step(input int m, input int p);
        bit adv, blanked;
        int k;
        if (reset) begin
            m_cnt[m] = 0; m_d[m] = 0; m_sh[m] = 16'h0;
            m_an[m] = 4'b1110; m_seg[m] = 7'h40; m_dp[m] = 1'b1; m_tk[m] = 1'b0;
        end else begin
            adv = (m_cnt[m] == p - 1);
            m_cnt[m] = adv ? 0 : m_cnt[m] + 1;
            m_tk[m] = adv;
            if (adv) begin
                m_d[m] = (m_d[m] + 1) % 4;
                k = m_d[m];
                blanked = blank_lz && (k > 0) && ((m_sh[m] >> (4 * k)) == 0);
                if (blanked) begin
                    m_an[m] = 4'b1111; m_seg[m] = 7'h7F; m_dp[m] = 1'b1;
                end else begin
                    m_an[m]  = 4'(~(4'b0001 << k));
                    m_seg[m] = hex_tab[(m_sh[m] >> (4 * k)) & 16'hF];
                    m_dp[m]  = ~dp_en[k];
                end
            end
            if (load) m_sh[m] = value;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4);
        model_step(1, 1);
        started = 1;
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            check("m4_digit_sel", 16'(ds4), 16'(4'b0001 << m_d[0]));
            check("m4_an", 16'(an4), 16'(m_an[0]));
            check("m4_seg", 16'(seg4), 16'(m_seg[0]));
            check("m4_dp", 16'(dp4), 16'(m_dp[0]));
            check("m4_tick", 16'(tk4), 16'(m_tk[0]));
            check("m1_digit_sel", 16'(ds1), 16'(4'b0001 << m_d[1]));
            check("m1_an", 16'(an1), 16'(m_an[1]));
            check("m1_seg", 16'(seg1), 16'(m_seg[1]));
            check("m1_dp", 16'(dp1), 16'(m_dp[1]));
            check("m1_tick", 16'(tk1), 16'(m_tk[1]));
        end
    end

    // Wait for the start of a new slot on the given digit of the PRESCALE=4 instance
    task automatic wait_digit(input logic [3:0] t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tk4 === 1'b1 && ds4 === t) && n < 40);
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL wait_digit: digit_sel %b never reached %b", ds4, t);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [3:0] exp_seq [3] = '{4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev1;
    logic       exp_dp;

    initial begin
        reset = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0; dp_en = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_digit_sel", 16'(ds4), 16'h1);
        check("rst_an", 16'(an4), 16'hE);
        check("rst_seg", 16'(seg4), 16'h40);
        check("rst_dp", 16'(dp4), 16'h1);
        check("rst_tick", 16'(tk4), 16'h0);
        reset = 1'b0;

        // rotation timing: first advance 4 cycles after release, then every 4
        repeat (3) @(negedge clk);
        check("pre_first_adv_sel", 16'(ds4), 16'h1);
        check("pre_first_adv_tick", 16'(tk4), 16'h0);
        @(negedge clk);
        check("first_adv_sel", 16'(ds4), 16'h2);
        check("first_adv_tick", 16'(tk4), 16'h1);
        for (int i = 0; i < 3; i++) begin
            repeat (3) begin
                @(negedge clk);
                check("mid_slot_tick", 16'(tk4), 16'h0);
            end
            @(negedge clk);
            check("rot_sel", 16'(ds4), 16'(exp_seq[i]));
            check("rot_tick", 16'(tk4), 16'h1);
        end

        // display 1A3F
        pulse_load(16'h1A3F);
        wait_digit(4'b0001);
        check("v_d0_seg", 16'(seg4), 16'h0E); check("v_d0_an", 16'(an4), 16'hE);
        wait_digit(4'b0010);
        check("v_d1_seg", 16'(seg4), 16'h30); check("v_d1_an", 16'(an4), 16'hD);
        wait_digit(4'b0100);
        check("v_d2_seg", 16'(seg4), 16'h08); check("v_d2_an", 16'(an4), 16'hB);
        wait_digit(4'b1000);
        check("v_d3_seg", 16'(seg4), 16'h79); check("v_d3_an", 16'(an4), 16'h7);

        // leading-zero blanking
        blank_lz = 1'b1;
        pulse_load(16'h0050);
        wait_digit(4'b1000);
        check("lz_d3_an", 16'(an4), 16'hF); check("lz_d3_seg", 16'(seg4), 16'h7F);
        wait_digit(4'b0001);
        check("lz_d0_seg", 16'(seg4), 16'h40); check("lz_d0_an", 16'(an4), 16'hE);
        wait_digit(4'b0010);
        check("lz_d1_seg", 16'(seg4), 16'h12); check("lz_d1_an", 16'(an4), 16'hD);
        wait_digit(4'b0100);
        check("lz_d2_an", 16'(an4), 16'hF); check("lz_d2_seg", 16'(seg4), 16'h7F);
        pulse_load(16'h0000);
        wait_digit(4'b1000);
        check("z_d3_an", 16'(an4), 16'hF);
        wait_digit(4'b0001);
        check("z_d0_an", 16'(an4), 16'hE); check("z_d0_seg", 16'(seg4), 16'h40);
        wait_digit(4'b0010);
        check("z_d1_an", 16'(an4), 16'hF); check("z_d1_dp", 16'(dp4), 16'h1);

        // load coincident with an advance edge
        blank_lz = 1'b0;
        pulse_load(16'h1111);
        wait_digit(4'b0001);
        check("co_pre_seg", 16'(seg4), 16'h79);
        repeat (3) @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("co_adv_tick", 16'(tk4), 16'h1);
        check("co_adv_seg_old", 16'(seg4), 16'h79);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("co_next_tick", 16'(tk4), 16'h1);
        check("co_next_seg_new", 16'(seg4), 16'h24);

        // reset in the middle of a digit-2 slot
        wait_digit(4'b0100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_sel", 16'(ds4), 16'h1);
        check("mr_seg", 16'(seg4), 16'h40);
        check("mr_an", 16'(an4), 16'hE);
        repeat (3) @(negedge clk);
        check("mr_no_early_adv", 16'(ds4), 16'h1);
        @(negedge clk);
        check("mr_first_adv", 16'(ds4), 16'h2);
        check("mr_first_tick", 16'(tk4), 16'h1);
        check("mr_shadow_cleared", 16'(seg4), 16'h40);

        // decimal points on digits 0 and 2, PRESCALE=1 instance advances every cycle
        dp_en = 4'b0101;
        pulse_load(16'h1234);
        prev1 = ds1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("p1_tick", 16'(tk1), 16'h1);
            total++;
            if (ds1 === prev1) begin
                bad++;
                $display("FAIL p1_advance: digit_sel stayed %b", ds1);
            end
            case (ds1)
                4'b0001: exp_dp = 1'b0;
                4'b0010: exp_dp = 1'b1;
                4'b0100: exp_dp = 1'b0;
                default: exp_dp = 1'b1;
            endcase
            check("p1_dp", 16'(dp1), 16'(exp_dp));
            prev1 = ds1;
        end
        wait_digit(4'b0100);
        check("dp_d2", 16'(dp4), 16'h0);
        wait_digit(4'b1000);
        check("dp_d3", 16'(dp4), 16'h1);
        wait_digit(4'b0001);
        check("dp_d0", 16'(dp4), 16'h0);
        check("dp_d0_seg", 16'(seg4), 16'h19);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
